dma_copy_engine: RTL and testbench

- Bus initiator that copies a block of 32-bit words from one RAM region to another.
- Drives the same single-port RAM interface the processor uses: byte address, R_W (1=write), CS, and the shared tri-state Data bus.
- Requests the bus with a BusReq/BusGnt handshake, so the top-level arbiter can stall the processor while a copy runs.
- Performs one read cycle, then one write cycle, per word.

---
 rtl/dma_copy_engine.sv | 115 +++++++++++
 tb/tb_dma_copy_engine.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dma_copy_engine.sv
// Word-by-word block copier: reads a word from the source region, then writes
// it to the destination region, holding a bus request for the whole transfer.
module dma_copy_engine #(
  parameter int LEN_W  = 12,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [LEN_W-1:0]  Len,
  input  logic              BusGnt,
  output logic              BusReq,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Addr,
  output logic              R_W,
  output logic              CS,
  inout  wire  [31:0]       Data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [31:0]       buf_q;
  logic              busy_q, busreq_q, done_q;

  logic              cs_d, rw_d;
  logic [ADDR_W-1:0] addr_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      buf_q    <= '0;
      busy_q   <= 1'b0;
      busreq_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            src_q <= SrcAddr & ~ADDR_W'(3);
            dst_q <= DstAddr & ~ADDR_W'(3);
            cnt_q <= Len;
            if (Len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= READ;
              busy_q   <= 1'b1;
              busreq_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (BusGnt) begin
            buf_q   <= Data;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (BusGnt) begin
            src_q <= src_q + ADDR_W'(4);
            dst_q <= dst_q + ADDR_W'(4);
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              busreq_q <= 1'b0;
            end else begin
              state_q <= READ;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus strobes follow the grant combinationally; RST also masks them so a
  // write scheduled for the reset edge never reaches the RAM.
  always_comb begin
    cs_d   = 1'b0;
    rw_d   = 1'b0;
    addr_d = '0;
    if (!RST && BusGnt) begin
      if (state_q == READ) begin
        cs_d   = 1'b1;
        addr_d = src_q;
      end else if (state_q == WRITE) begin
        cs_d   = 1'b1;
        rw_d   = 1'b1;
        addr_d = dst_q;
      end
    end
  end

  assign CS     = cs_d;
  assign R_W    = rw_d;
  assign Addr   = addr_d;
  assign Data   = (cs_d && rw_d) ? buf_q : 'z;
  assign Busy   = busy_q;
  assign BusReq = busreq_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine: a table of copy scenarios run against a
// behavioural single-port RAM, plus a hand-written reset-mid-copy sequence.
module tb_dma_copy_engine;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [31:0] SrcAddr, DstAddr;
  logic [11:0] Len;
  logic        BusGnt;
  logic        BusReq, Busy, Done, R_W, CS;
  logic [31:0] Addr;
  wire  [31:0] Data;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram [0:1023];
  logic        pre_en = 1'b0;

  always #5 CLK = ~CLK;

  dma_copy_engine #(.LEN_W(12), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .Len(Len), .BusGnt(BusGnt), .BusReq(BusReq), .Busy(Busy), .Done(Done),
    .Addr(Addr), .R_W(R_W), .CS(CS), .Data(Data)
  );

  assign Data = (CS && !R_W) ? ram[Addr[11:2]] : 'z;

  always @(posedge CLK) begin
    if (pre_en) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
    end else if (CS && R_W) begin
      ram[Addr[11:2]] <= Data;
    end
  end

  function automatic logic [31:0] init_val(int i);
    return 32'(i) + 32'h60;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [11:0] len;
    int          stall_at;
    int          stall_len;
    int          restart_at;
    logic        overlap;
    int          exp_done;
  } vec_t;

  task automatic run_copy(input vec_t v);
    int done_cyc, done_n, busy_n, req_n, cs_n, wr_n, mis_n, stall_bad;
    int sw, dw;
    pre_en = 1'b1;
    @(posedge CLK); #1;
    pre_en  = 1'b0;
    SrcAddr = v.src;
    DstAddr = v.dst;
    Len     = v.len;
    BusGnt  = 1'b1;
    Start   = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    done_cyc = 0; done_n = 0; busy_n = 0; req_n = 0;
    cs_n = 0; wr_n = 0; mis_n = 0; stall_bad = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      BusGnt = !(v.stall_len > 0 && cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
      if (cyc == v.restart_at) begin
        Start = 1'b1; SrcAddr = 32'h800; DstAddr = 32'h700; Len = 12'd1;
      end else begin
        Start = 1'b0;
      end
      @(negedge CLK);
      if (Done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (Busy) busy_n++;
      if (BusReq) req_n++;
      if (CS) cs_n++;
      if (CS && R_W) wr_n++;
      if (CS && Addr[1:0] != 2'b00) mis_n++;
      if (!BusGnt && (CS || R_W)) stall_bad++;
      @(posedge CLK); #1;
      if (done_cyc != 0 && cyc >= done_cyc + 2) break;
    end
    Start  = 1'b0;
    BusGnt = 1'b1;
    check("done_cycle", 32'(done_cyc), 32'(v.exp_done));
    check("done_pulses", 32'(done_n), 32'd1);
    check("busy_cycles", 32'(busy_n), 32'(v.exp_done - 1));
    check("busreq_cycles", 32'(req_n), 32'(v.exp_done - 1));
    check("cs_cycles", 32'(cs_n), 32'(2 * int'(v.len)));
    check("write_cycles", 32'(wr_n), 32'(v.len));
    check("misaligned_access", 32'(mis_n), 32'd0);
    check("stall_drive", 32'(stall_bad), 32'd0);
    sw = int'(v.src >> 2);
    dw = int'(v.dst >> 2);
    for (int k = 0; k < int'(v.len); k++)
      check("dst_word", ram[dw + k], v.overlap ? init_val(sw) : init_val(sw + k));
    check("word_after_dst", ram[dw + int'(v.len)], init_val(dw + int'(v.len)));
  endtask

  vec_t vecs [6];

  initial begin
    // src, dst, len, stall_at, stall_len, restart_at, overlap, exp_done
    vecs[0] = '{32'h100, 32'h200, 12'd4, 0, 0, 0, 1'b0, 9};
    vecs[1] = '{32'h100, 32'h200, 12'd0, 0, 0, 0, 1'b0, 1};
    vecs[2] = '{32'h100, 32'h240, 12'd3, 4, 3, 0, 1'b0, 10};
    vecs[3] = '{32'h103, 32'h302, 12'd2, 0, 0, 0, 1'b0, 5};
    vecs[4] = '{32'h100, 32'h600, 12'd3, 0, 0, 2, 1'b0, 7};
    vecs[5] = '{32'h400, 32'h404, 12'd3, 0, 0, 0, 1'b1, 7};

    RST = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0; BusGnt = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busreq", 32'(BusReq), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_cs", 32'(CS), 32'd0);
    check("rst_rw", 32'(R_W), 32'd0);
    check("rst_addr", Addr, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    foreach (vecs[i]) run_copy(vecs[i]);

    // Reset during the third word's write cycle (cycle 6 after the Start edge)
    pre_en = 1'b1;
    @(posedge CLK); #1;
    pre_en = 1'b0;
    SrcAddr = 32'h100; DstAddr = 32'h500; Len = 12'd5; BusGnt = 1'b1; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_cs", 32'(CS), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_busreq", 32'(BusReq), 32'd0);
    check("post_rst_busy", 32'(Busy), 32'd0);
    check("post_rst_done", 32'(Done), 32'd0);
    check("post_rst_cs", 32'(CS), 32'd0);
    check("post_rst_rw", 32'(R_W), 32'd0);
    check("post_rst_addr", Addr, 32'd0);
    check("rst_dst_w0", ram[32'h140], init_val(32'h40));
    check("rst_dst_w1", ram[32'h141], init_val(32'h41));
    check("rst_dst_w2", ram[32'h142], init_val(32'h142));
    @(posedge CLK); #1;
    run_copy('{32'h100, 32'h500, 12'd5, 0, 0, 0, 1'b0, 11});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
